// File: rtl/prog_loader.sv
// prog_loader: byte-stream framer that packs {HI,LO} pairs into
// instruction words, writes imem and holds the core in reset while loading.
module prog_loader #(
  parameter int                    DATA_WIDTH        = 11,
  parameter int                    INSTRUCTION_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR         = '0,
  parameter logic [7:0]            START_BYTE        = 8'hA5,
  parameter logic [4:0]            MAX_OPCODE        = 5'b01110
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid_in,
  output logic                         byte_ready_out,
  output logic [DATA_WIDTH-1:0]        imem_addr_out,
  output logic [INSTRUCTION_WIDTH-1:0] imem_data_out,
  output logic                         imem_wr_out,
  output logic                         cpu_reset_n_out,
  output logic                         done_out,
  output logic                         error_out,
  output logic [1:0]                   error_code_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHECK,
    S_ERROR
  } state_t;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_ZERO  = 2'b01;
  localparam logic [1:0] E_OPC   = 2'b10;
  localparam logic [1:0] E_CSUM  = 2'b11;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] hi_q;
  logic [7:0] csum_q;
  logic [7:0] remaining_q;

  logic accept;
  logic is_start;
  logic bad_opc;
  logic csum_ok;

  assign accept   = byte_valid_in & byte_ready_out;
  assign is_start = byte_in == START_BYTE;
  assign bad_opc  = hi_q[7:3] > MAX_OPCODE;
  assign csum_ok  = byte_in == csum_q;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE,
      S_ERROR: begin
        if (accept && is_start) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (accept) begin
          state_d = (byte_in == 8'd0) ? S_ERROR : S_HI;
        end
      end
      S_HI: begin
        if (accept) state_d = S_LO;
      end
      S_LO: begin
        if (accept) state_d = bad_opc ? S_ERROR : S_WRITE;
      end
      S_WRITE: begin
        state_d = (remaining_q == 8'd1) ? S_CHECK : S_HI;
      end
      S_CHECK: begin
        if (accept) state_d = csum_ok ? S_IDLE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Core is free only when idle: a clean reset or a frame that
  // finished with a good checksum.
  always_comb begin
    byte_ready_out  = state_q != S_WRITE;
    imem_wr_out     = state_q == S_WRITE;
    cpu_reset_n_out = state_q == S_IDLE;
    error_out       = state_q == S_ERROR;
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      hi_q           <= '0;
      csum_q         <= '0;
      remaining_q    <= '0;
      imem_addr_out  <= BASE_ADDR;
      imem_data_out  <= '0;
      done_out       <= 1'b0;
      error_code_out <= E_NONE;
    end else begin
      unique case (state_q)
        S_IDLE,
        S_ERROR: begin
          if (accept && is_start) begin
            csum_q         <= '0;
            done_out       <= 1'b0;
            error_code_out <= E_NONE;
          end
        end
        S_COUNT: begin
          if (accept) begin
            if (byte_in == 8'd0) begin
              error_code_out <= E_ZERO;
            end else begin
              remaining_q   <= byte_in;
              imem_addr_out <= BASE_ADDR;
            end
          end
        end
        S_HI: begin
          if (accept) begin
            hi_q   <= byte_in;
            csum_q <= csum_q ^ byte_in;
          end
        end
        S_LO: begin
          if (accept) begin
            csum_q <= csum_q ^ byte_in;
            if (bad_opc) begin
              error_code_out <= E_OPC;
            end else begin
              imem_data_out <= {hi_q, byte_in};
            end
          end
        end
        S_WRITE: begin
          imem_addr_out <= imem_addr_out + 1'b1;
          remaining_q   <= remaining_q - 8'd1;
        end
        S_CHECK: begin
          if (accept) begin
            if (csum_ok) begin
              done_out <= 1'b1;
            end else begin
              error_code_out <= E_CSUM;
            end
          end
        end
        default: begin
          hi_q <= hi_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench; a frame-level model predicts
// the imem writes and final status, a monitor checks every write.
module tb_prog_loader;

  localparam logic [10:0] BASE = 11'h7FE;

  logic        clock_in;
  logic        reset_in;
  logic [7:0]  byte_in;
  logic        byte_valid_in;
  logic        byte_ready_out;
  logic [10:0] imem_addr_out;
  logic [15:0] imem_data_out;
  logic        imem_wr_out;
  logic        cpu_reset_n_out;
  logic        done_out;
  logic        error_out;
  logic [1:0]  error_code_out;

  typedef struct packed {
    logic [10:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t sb[$];
  int  errors = 0;
  int  checks = 0;
  bit  prev_wr = 0;

  prog_loader #(.BASE_ADDR(BASE)) u_dut (
    .clock_in(clock_in),
    .reset_in(reset_in),
    .byte_in(byte_in),
    .byte_valid_in(byte_valid_in),
    .byte_ready_out(byte_ready_out),
    .imem_addr_out(imem_addr_out),
    .imem_data_out(imem_data_out),
    .imem_wr_out(imem_wr_out),
    .cpu_reset_n_out(cpu_reset_n_out),
    .done_out(done_out),
    .error_out(error_out),
    .error_code_out(error_code_out)
  );

  initial clock_in = 0;
  always #5 clock_in = ~clock_in;

  task automatic check(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge clock_in) begin
    if (reset_in && imem_wr_out) begin
      if (sb.size() == 0) begin
        check("unexpected_write", int'(imem_addr_out), -1);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", int'(imem_addr_out), int'(e.addr));
        check("wr_data", int'(imem_data_out), int'(e.data));
      end
      check("ready_in_write", int'(byte_ready_out), 0);
      check("core_held", int'(cpu_reset_n_out), 0);
      check("wr_width", int'(prev_wr), 0);
    end
    prev_wr = reset_in && imem_wr_out;
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc;
    int tries;
    if (gaps) begin
      byte_valid_in = 0;
      repeat ($urandom_range(0, 2)) @(negedge clock_in);
    end
    byte_in = b;
    byte_valid_in = 1;
    acc = 0;
    tries = 0;
    while (!acc && tries < 20) begin
      #1 acc = byte_ready_out;
      @(negedge clock_in);
      tries++;
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic send_stream(input logic [7:0] q[$], input bit gaps);
    foreach (q[i]) send_byte(q[i], gaps);
    byte_valid_in = 0;
  endtask

  task automatic check_status(input string n, input int code);
    bit ok;
    ok = code == 0;
    check({n, "_done"}, int'(done_out), int'(ok));
    check({n, "_error"}, int'(error_out), int'(!ok));
    check({n, "_code"}, int'(error_code_out), code);
    check({n, "_cpu_rst_n"}, int'(cpu_reset_n_out), int'(ok));
    check({n, "_pending"}, sb.size(), 0);
  endtask

  function automatic wr_t mk(input int i, input logic [15:0] d);
    wr_t w;
    w.addr = BASE + 11'(i);
    w.data = d;
    return w;
  endfunction

  // kind: 0 good, 1 zero count, 2 illegal opcode, 3 bad checksum
  task automatic random_frame(input int kind, input bit gaps);
    logic [7:0] q[$];
    logic [7:0] hi, lo, cs, b;
    int cnt, bad;
    q = {};
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      q.push_back(b);
    end
    q.push_back(8'hA5);
    if (kind == 1) begin
      q.push_back(8'h00);
    end else begin
      cnt = $urandom_range(1, 6);
      bad = (kind == 2) ? $urandom_range(0, cnt - 1) : cnt;
      q.push_back(8'(cnt));
      cs = 0;
      for (int i = 0; i < cnt; i++) begin
        hi = {5'($urandom_range(0, 14)), 3'($urandom)};
        if (i == bad) hi[7:3] = 5'($urandom_range(15, 31));
        lo = 8'($urandom);
        cs = cs ^ hi ^ lo;
        q.push_back(hi);
        q.push_back(lo);
        if (i == bad) break;
        sb.push_back(mk(i, {hi, lo}));
      end
      if (kind == 0) q.push_back(cs);
      if (kind == 3) q.push_back(cs ^ 8'($urandom_range(1, 255)));
    end
    send_stream(q, gaps);
    check_status("rand", kind);
  endtask

  initial begin
    reset_in = 0;
    byte_in = 0;
    byte_valid_in = 0;
    repeat (2) @(negedge clock_in);
    check("rst_addr", int'(imem_addr_out), int'(BASE));
    check("rst_data", int'(imem_data_out), 0);
    check("rst_wr", int'(imem_wr_out), 0);
    check("rst_cpu", int'(cpu_reset_n_out), 1);
    check("rst_flags", int'({done_out, error_out, error_code_out}), 0);
    check("rst_ready", int'(byte_ready_out), 1);
    reset_in = 1;
    @(negedge clock_in);

    sb.push_back(mk(0, 16'h1805));
    sb.push_back(mk(1, 16'h210A));
    send_stream('{8'hA5, 8'h02, 8'h18, 8'h05, 8'h21, 8'h0A, 8'h36}, 0);
    check_status("two_words", 0);

    send_stream('{8'hA5, 8'h01, 8'h78, 8'h00}, 0);
    check_status("bad_opcode", 2);

    sb.push_back(mk(0, 16'h1805));
    sb.push_back(mk(1, 16'h210A));
    send_stream('{8'hA5, 8'h02, 8'h18, 8'h05, 8'h21, 8'h0A, 8'h36}, 1);
    check_status("recover", 0);

    sb.push_back(mk(0, 16'h1805));
    send_stream('{8'hA5, 8'h01, 8'h18, 8'h05, 8'h00}, 0);
    check_status("bad_csum", 3);

    send_stream('{8'h00, 8'hFF, 8'hA5, 8'h00}, 0);
    check_status("zero_count", 1);

    sb.push_back(mk(0, 16'h0001));
    sb.push_back(mk(1, 16'h0002));
    sb.push_back(mk(2, 16'h0003));
    send_stream('{8'hA5, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02,
                  8'h00, 8'h03, 8'h00}, 0);
    check_status("addr_wrap", 0);

    sb.push_back(mk(0, 16'h10A5));
    send_stream('{8'hA5, 8'h01, 8'h10, 8'hA5, 8'hB5}, 0);
    check_status("start_as_data", 0);

    send_stream('{8'hA5, 8'h02, 8'h18}, 0);
    reset_in = 0;
    #1;
    check("mid_rst_wr", int'(imem_wr_out), 0);
    check("mid_rst_cpu", int'(cpu_reset_n_out), 1);
    check("mid_rst_addr", int'(imem_addr_out), int'(BASE));
    check("mid_rst_data", int'(imem_data_out), 0);
    check("mid_rst_flags", int'({done_out, error_out, error_code_out}), 0);
    @(negedge clock_in);
    reset_in = 1;
    @(negedge clock_in);
    sb.push_back(mk(0, 16'h1805));
    sb.push_back(mk(1, 16'h210A));
    send_stream('{8'hA5, 8'h02, 8'h18, 8'h05, 8'h21, 8'h0A, 8'h36}, 0);
    check_status("after_rst", 0);

    for (int f = 0; f < 40; f++) begin
      int k;
      k = $urandom_range(0, 5);
      if (k > 3) k = 0;
      random_frame(k, 1'($urandom));
    end

    repeat (3) @(negedge clock_in);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader that encodes incoming bytes into 16-bit instruction words ({opcode[4:0], operand[10:0]}) and writes them into instruction memory.
- Checks each opcode against the ISA range (HLT 00000 .. JMP 01110) and checks a frame checksum.
- Holds the CPU core in reset while a load is in progress.
- Sits between the host byte link (UART/debug bridge) and the instruction memory write port, alongside the core's control unit.

Parameters:
- DATA_WIDTH, 11, operand / instruction-address width.
- INSTRUCTION_WIDTH, 16, instruction word width. Only 16 is supported (two bytes per word). Opcode is the top INSTRUCTION_WIDTH-DATA_WIDTH = 5 bits.
- BASE_ADDR, 0, first instruction-memory address written by each frame.
- START_BYTE, 8'hA5, frame start marker.
- MAX_OPCODE, 5'b01110, highest legal opcode.

Ports:
- clock_in  in  1  clock; all state updates on rising edge.
- reset_in  in  1  reset, asynchronous, active-low.
- byte_in  in  8  incoming data byte.
- byte_valid_in  in  1  byte_in is valid.
- byte_ready_out  out  1  loader can accept a byte this cycle.
- imem_addr_out  out  DATA_WIDTH  instruction memory write address.
- imem_data_out  out  INSTRUCTION_WIDTH  instruction word to write.
- imem_wr_out  out  1  write strobe, one cycle per word.
- cpu_reset_n_out  out  1  active-low reset to the core; low while loading or after error.
- done_out  out  1  last frame loaded successfully (sticky).
- error_out  out  1  last frame aborted (sticky).
- error_code_out  out  2  00 none, 01 zero count, 10 illegal opcode, 11 checksum mismatch.

Behaviour:
Reset and handshake
- Reset (async, reset_in=0):
  - state=IDLE, imem_wr_out=0, imem_addr_out=BASE_ADDR, imem_data_out=0.
  - cpu_reset_n_out=1, done_out=0, error_out=0, error_code_out=00.
  - Internal checksum and remaining count cleared.
- Acceptance: a byte is accepted on a rising edge with byte_valid_in=1 and byte_ready_out=1. byte_ready_out is combinational from state: 1 in every state except WRITE.
- Frame format: START_BYTE, COUNT (1..255), COUNT x {HI, LO}, CSUM. CSUM is the XOR of all HI/LO bytes. Word = {HI, LO}; opcode = HI[7:3].

State machine (IDLE, COUNT, HI, LO, WRITE, CHECK, ERROR)
- IDLE:
  - Accepted byte == START_BYTE -> COUNT. Same edge: cpu_reset_n_out<=0, done_out<=0, error_out<=0, error_code_out<=00, csum<=0.
  - Any other accepted byte is discarded; stay IDLE.
- COUNT:
  - Accepted 0 -> ERROR, code 01.
  - Otherwise remaining<=byte, imem_addr_out<=BASE_ADDR -> HI.
- HI: accept; hi_reg<=byte; csum^=byte -> LO.
- LO: accept; csum^=byte.
  - If hi_reg[7:3] > MAX_OPCODE -> ERROR, code 10; no write issued.
  - Otherwise imem_data_out<={hi_reg, byte}, imem_wr_out<=1 -> WRITE.
- WRITE: exactly one cycle with imem_wr_out=1, address/data stable. Next edge:
  - imem_wr_out<=0, imem_addr_out<=imem_addr_out+1, remaining<=remaining-1.
  - -> CHECK if remaining==1, else -> HI.
- CHECK: accept.
  - Byte == csum -> IDLE with done_out<=1, cpu_reset_n_out<=1.
  - Otherwise -> ERROR, code 11.
- ERROR:
  - error_out=1; cpu_reset_n_out stays 0; byte_ready_out=1.
  - Accepted START_BYTE restarts the frame exactly as from IDLE. Other bytes are discarded.

Latency and arithmetic
- Word write strobe appears the cycle after the LO byte is accepted.
- Core is released the cycle after a correct CSUM is accepted.
- Address increment wraps modulo 2^DATA_WIDTH.
- csum is 8-bit XOR; START, COUNT and CSUM bytes are excluded.
- imem_data_out holds the last written word until the next write.

Boundary conditions
- Words written before an error are not rolled back; the core stays held until a good frame completes.
- byte_valid_in held high during WRITE: the byte is not consumed and is accepted the next cycle in HI/CHECK.
- Async reset mid-frame: immediate return to reset values; imem_wr_out drops in the same cycle; cpu_reset_n_out returns to 1.
- START_BYTE value received inside a frame is treated as data, not as a restart.

Test Plan:
- Stream A5 02 18 05 21 0A 36, valid every cycle -> writes 0x1805 @0 then 0x210A @1. Each imem_wr_out is 1 cycle wide. cpu_reset_n_out is low from the edge accepting A5 until the edge after 36. done_out=1, error_out=0.
- Stream A5 01 78 00 -> opcode 01111 > MAX_OPCODE: no imem_wr_out pulse; error_out=1, code 10; cpu_reset_n_out stays 0. Then send the first frame -> error cleared, done_out=1.
- Stream A5 01 18 05 00 (expected csum 1D) -> one write 0x1805 @0; error code 11; cpu_reset_n_out=0.
- Stream A5 00 -> error code 01, no writes. Leading junk bytes 00 FF before A5 in IDLE -> ignored.
- BASE_ADDR=0x7FF, stream A5 02 00 01 00 02 03 -> writes @0x7FF then @0x000 (wrap); done_out=1.
- byte_valid_in held high continuously -> byte_ready_out=0 during each WRITE cycle and no byte is lost. reset_in pulsed low after the HI byte -> outputs at reset values immediately; the next frame loads correctly from BASE_ADDR.
